// File: rtl/ones_idx_emitter.sv
// Walks a captured bit mask and hands out the index of each set bit, lowest index first.
// Define ONES_IDX_BACK2BACK_EN to accept the next vector on the final output handshake.
module ones_idx_emitter #(
  parameter  int unsigned LOG_VEC_SIZE = 3,
  localparam int unsigned VEC_SIZE     = 1 << LOG_VEC_SIZE,
  localparam int unsigned CNT_W        = LOG_VEC_SIZE + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:VEC_SIZE-1]     in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LOG_VEC_SIZE-1:0] out_idx,
  output logic                    out_last,
  output logic [CNT_W-1:0]        remaining,
  output logic                    busy
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                  state_q, state_d;
  logic [0:VEC_SIZE-1]     pending_q, pending_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        vec_pop_c;
  logic [LOG_VEC_SIZE-1:0] enc_idx_c;

  // Set-bit count of the offered vector; CNT_W bits so an all-ones mask fits.
  always_comb begin
    vec_pop_c = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      vec_pop_c = vec_pop_c + CNT_W'(in_vec[i]);
    end
  end

  // Lowest pending index; scanning downward lets the smallest hit win.
  always_comb begin
    enc_idx_c = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (pending_q[i]) enc_idx_c = LOG_VEC_SIZE'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    remaining = cnt_q;
    busy      = 1'b0;

    if (state_q == EMIT) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_idx   = enc_idx_c;
      out_last  = (cnt_q == CNT_W'(1));
`ifdef ONES_IDX_BACK2BACK_EN
      in_ready  = out_last & out_ready;
`endif
      if (out_ready) begin
        pending_d[enc_idx_c] = 1'b0;
        cnt_d                = cnt_q - CNT_W'(1);
        if (out_last) state_d = IDLE;
      end
    end else begin
      in_ready = 1'b1;
    end

    // A load overrides the retiring walk; an empty mask is consumed silently.
    if (in_valid && in_ready) begin
      pending_d = in_vec;
      cnt_d     = vec_pop_c;
      state_d   = (in_vec != '0) ? EMIT : IDLE;
    end
  end

endmodule

// File: doc/ones_idx_emitter.md
Name: ones_idx_emitter

Overview:
- Sequential inverse of the population counter: captures a bit vector and emits the index of each set bit, one per handshake, lowest index first.
- Also reports how many set bits remain.
- Used by the prefetcher to walk a hit/valid mask, which the popcount only summarizes, and issue one request per set entry.

Parameters:
- LOG_VEC_SIZE, 3, log2 of vector width
- VEC_SIZE, 1<<LOG_VEC_SIZE, vector width (derived; do not override independently)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_vec is offered
- in_ready  output  1  block accepts a new vector
- in_vec  input  [0:VEC_SIZE-1]  mask to walk; bit 0 is the leftmost/MSB position
- out_valid  output  1  out_idx holds a valid index
- out_ready  input  1  consumer accepts out_idx
- out_idx  output  LOG_VEC_SIZE  index of the lowest pending set bit
- out_last  output  1  current out_idx is the final set bit
- remaining  output  LOG_VEC_SIZE+1  set bits not yet handed off, including the current one
- busy  output  1  state is EMIT

Behaviour:
- Registers:
  - pending[0:VEC_SIZE-1]
  - cnt[LOG_VEC_SIZE:0]
  - state, one of IDLE or EMIT
- Reset (async, rst=1), takes effect immediately:
  - state=IDLE, pending=0, cnt=0
  - outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0, remaining=0, busy=0
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: pending<=in_vec and cnt<=popcount(in_vec). Popcount is combinational; width LOG_VEC_SIZE+1 so VEC_SIZE ones does not overflow.
  - If in_vec!=0, next state is EMIT. If in_vec==0, the vector is consumed and state stays IDLE; no output is produced.
- EMIT:
  - out_valid=1, in_ready=0 (see optional feature).
  - out_idx = smallest i with pending[i]=1. Combinational priority encode of registered pending, so no extra latency.
  - remaining=cnt. out_last=(cnt==1).
  - On out_valid&out_ready: clear pending[out_idx], cnt<=cnt-1. If out_last, next state is IDLE.
  - With out_ready=0: hold every output stable. out_idx must not change while stalled.
- Latency:
  - First index is valid the cycle after the input handshake.
  - A vector with k set bits needs k output handshakes. Throughput is 1 index/cycle with out_ready held high.
- Invariant: cnt always equals popcount(pending). The bench checks this every cycle.
- In IDLE, out_idx and out_last are driven 0.
- A full vector (all ones) emits 0..VEC_SIZE-1 in order, with remaining starting at VEC_SIZE.
- Reset asserted mid-walk discards the remaining indices. No partial output follows reset release.
- in_valid while in EMIT is ignored. The producer must hold the vector until in_ready.

Optional Feature:
- Macro: ONES_IDX_BACK2BACK_EN
- Defined:
  - in_ready = IDLE | (EMIT & out_last & out_ready), so the next vector loads in the same cycle as the final output handshake.
  - That load behaves exactly like an IDLE load, including the zero-vector case, which goes to IDLE.
  - This gives zero bubble cycles between vectors.
- Undefined: in_ready = (state==IDLE), giving one idle cycle between consecutive non-zero vectors.

Test Plan:
- LOG_VEC_SIZE=3, reset, in_vec=8'b1010_0001 (bits 0,2,7), out_ready=1 -> out_idx 0,2,7 on consecutive cycles; remaining 3,2,1; out_last only with idx 7; then IDLE, in_ready=1.
- in_vec=8'hFF, out_ready toggling 1,0,1,0... -> idx 0..7 in order; out_idx/remaining held stable on every stalled cycle; 8 handshakes total.
- in_vec=8'h00 accepted -> out_valid never rises; in_ready stays 1; next in_vec=8'b0000_0001 -> single idx 7 with out_last=1, remaining=1.
- Load 8'b1100_0000, emit idx 0, assert rst for one cycle mid-walk -> immediately out_valid=0, remaining=0; after release no idx 1 is emitted.
- Back-to-back 8'b1000_0000 then 8'b0100_0000 with in_valid held -> with ONES_IDX_BACK2BACK_EN: idx 0 then idx 1 on consecutive cycles; without: one cycle out_valid=0 between them.
- Random vectors, 1000 iterations -> emitted index set equals the set bits of each vector, strictly ascending; the cnt==popcount(pending) check never fails.
